// File: rtl/tm_pkg.sv
// Shared types and defaults for the transaction-metrics monitor.
package tm_pkg;

  localparam int unsigned TmW          = 8;
  localparam int unsigned TmAluLatency = 4;
  localparam logic [TmW-1:0] TmSatMax  = '1;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StIssue,
    StWait,
    StCommit
  } tm_state_e;

endpackage

// File: rtl/tm_len_counter.sv
// Start/stop saturating cycle counter that yields the current transaction length.
module tm_len_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         zero,
  input  logic         run,
  output logic [W-1:0] cur
);

  localparam logic [W-1:0] Max = '1;

  logic [W-1:0] cnt_q;

  // A start loads 1 so that an end n cycles later leaves exactly n in the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= zero ? '0 : W'(1);
    end else if (run && (cnt_q != Max)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cur = cnt_q;

endmodule

// File: rtl/tm_tx_monitor.sv
// Transaction-length monitor: measures each transaction, drives the metrics ALU and commits results.
module tm_tx_monitor
  import tm_pkg::*;
#(
  parameter int unsigned W           = TmW,
  parameter int unsigned ALU_LATENCY = TmAluLatency
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_start,
  input  logic         tx_end,
  output logic [W-1:0] alu_avg,
  output logic [W-1:0] alu_inst,
  output logic [W-1:0] alu_cur,
  input  logic [W-1:0] alu_avg_new,
  input  logic [W-1:0] alu_inst_new,
  output logic [W-1:0] avg_tx_len,
  output logic [W-1:0] inst_exed,
  output logic         busy,
  output logic         upd_done,
  output logic [W-1:0] drop_cnt,
  output logic         stat_sat
);

  localparam logic [W-1:0] Max      = '1;
  localparam int unsigned  WaitW    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(ALU_LATENCY - 1);

  tm_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q;
  logic [W-1:0]     alu_avg_q, alu_inst_q, alu_cur_q;
  logic [W-1:0]     avg_q, inst_q, drop_q;
  logic             upd_done_q, stat_sat_q;

  logic             cnt_start, cnt_zero, cnt_run;
  logic             sat_hit, drop_evt;
  logic [W-1:0]     cur;

  tm_len_counter #(
    .W (W)
  ) u_len_counter (
    .clk   (clk),
    .reset (reset),
    .start (cnt_start),
    .zero  (cnt_zero),
    .run   (cnt_run),
    .cur   (cur)
  );

  always_comb begin
    state_d   = state_q;
    cnt_start = 1'b0;
    cnt_zero  = 1'b0;
    sat_hit   = 1'b0;
    drop_evt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          cnt_start = 1'b1;
          cnt_zero  = tx_end;
          if (!tx_end) begin
            state_d = StCount;
          end else if (inst_q == Max) begin
            sat_hit = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StCount: begin
        if (tx_end) begin
          drop_evt = tx_start;
          if (inst_q == Max) begin
            sat_hit = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        drop_evt = tx_start;
        state_d  = StWait;
      end
      StWait: begin
        drop_evt = tx_start;
        if (wait_q == WaitLast) state_d = StCommit;
      end
      StCommit: begin
        drop_evt = tx_start;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The counter freezes on the end cycle so ISSUE can still pick up the final length.
  assign cnt_run = (state_q == StCount) && !tx_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      alu_avg_q  <= '0;
      alu_inst_q <= '0;
      alu_cur_q  <= '0;
      avg_q      <= '0;
      inst_q     <= '0;
      drop_q     <= '0;
      upd_done_q <= 1'b0;
      stat_sat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= (state_q == StWait) ? wait_q + WaitW'(1) : '0;
      upd_done_q <= (state_q == StCommit);
      if (state_q == StIssue) begin
        alu_avg_q  <= avg_q;
        alu_inst_q <= inst_q;
        alu_cur_q  <= cur;
      end
      if (state_q == StCommit) begin
        avg_q  <= alu_avg_new;
        inst_q <= alu_inst_new;
      end
      if (sat_hit) stat_sat_q <= 1'b1;
      if (drop_evt && (drop_q != Max)) drop_q <= drop_q + W'(1);
    end
  end

  assign alu_avg    = alu_avg_q;
  assign alu_inst   = alu_inst_q;
  assign alu_cur    = alu_cur_q;
  assign avg_tx_len = avg_q;
  assign inst_exed  = inst_q;
  assign drop_cnt   = drop_q;
  assign upd_done   = upd_done_q;
  assign stat_sat   = stat_sat_q;
  assign busy       = (state_q == StIssue) || (state_q == StWait);

endmodule
